// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one word read at a time to instruction memory,
// and buffers returned words with their PCs for the decoder.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_valid,
  input  logic [31:0]           imem_rdata,
  output logic                  insn_valid,
  output logic [31:0]           insn,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  input  logic                  insn_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetchStateT;

  fetchStateT            stateReg, stateNext;
  logic [ADDR_WIDTH-1:0] pcReg, pcNext, reqPcReg;
  logic [31:0]           bufWord [DEPTH];
  logic [ADDR_WIDTH-1:0] bufPc   [DEPTH];
  logic [PTR_W-1:0]      headReg, tailReg;
  logic [CNT_W-1:0]      countReg;
  logic                  reqOk, accept, push, pop, outstanding, bufNotEmpty;

  // Handshake decode and next-state/PC selection; redirect overrides everything.
  always_comb begin
    stateNext   = stateReg;
    pcNext      = pcReg;
    outstanding = (stateReg != FETCH);
    bufNotEmpty = (countReg != {CNT_W{1'b0}});
    reqOk       = rst_n && (stateReg == FETCH) && (countReg < CNT_W'(DEPTH));
    accept      = reqOk && imem_ready;
    pop         = bufNotEmpty && insn_ready;
    push        = (stateReg == WAIT) && imem_valid && !redirect_valid;
    if (redirect_valid) begin
      pcNext = redirect_pc & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
      // A response arriving this cycle closes the outstanding request, so no drop needed.
      if (accept || (outstanding && !imem_valid)) begin
        stateNext = DROP;
      end else begin
        stateNext = FETCH;
      end
    end else begin
      case (stateReg)
        FETCH: begin
          if (accept) begin
            pcNext    = pcReg + ADDR_WIDTH'(4);
            stateNext = WAIT;
          end else begin
            stateNext = FETCH;
          end
        end
        WAIT, DROP: begin
          if (imem_valid) begin
            stateNext = FETCH;
          end else begin
            stateNext = stateReg;
          end
        end
        default: stateNext = FETCH;
      endcase
    end
  end

  // State, PC and buffer pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= FETCH;
      pcReg    <= RESET_PC;
      reqPcReg <= RESET_PC;
      headReg  <= {PTR_W{1'b0}};
      tailReg  <= {PTR_W{1'b0}};
      countReg <= {CNT_W{1'b0}};
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      if (accept) begin
        reqPcReg <= pcReg;
      end
      if (redirect_valid) begin
        headReg  <= {PTR_W{1'b0}};
        tailReg  <= {PTR_W{1'b0}};
        countReg <= {CNT_W{1'b0}};
      end else begin
        if (push) begin
          tailReg <= tailReg + PTR_W'(1);
        end
        if (pop) begin
          headReg <= headReg + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   countReg <= countReg + CNT_W'(1);
          2'b01:   countReg <= countReg - CNT_W'(1);
          default: countReg <= countReg;
        endcase
      end
    end
  end

  // Buffer storage; cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bufWord[i] <= 32'h0000_0000;
        bufPc[i]   <= {ADDR_WIDTH{1'b0}};
      end
    end else if (push) begin
      bufWord[tailReg] <= imem_rdata;
      bufPc[tailReg]   <= reqPcReg;
    end
  end

  assign imem_req   = reqOk;
  assign imem_addr  = pcReg;
  assign insn_valid = bufNotEmpty;
  assign insn       = bufWord[headReg];
  assign insn_pc    = bufPc[headReg];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 1-cycle-latency memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        insn_valid;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_ready;

  int checks = 0;
  int errors = 0;
  logic        memAuto;
  logic [31:0] gotPc[$];
  logic [31:0] gotInsn[$];
  logic [31:0] reqAddr[$];

  instruction_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc), .insn_ready(insn_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hA5C3_0F96;
  endfunction

  // One clock: record consumed words and accepted requests, then let the memory respond.
  task automatic tick();
    logic        acc;
    logic [31:0] accAddr;
    #1;
    if (insn_valid && insn_ready) begin
      gotPc.push_back(insn_pc);
      gotInsn.push_back(insn);
    end
    acc     = rst_n && imem_req && imem_ready;
    accAddr = imem_addr;
    if (acc) reqAddr.push_back(accAddr);
    @(posedge clk);
    #1;
    if (memAuto) begin
      imem_valid = acc;
      imem_rdata = acc ? memData(accAddr) : 32'h0000_0000;
    end
  endtask

  task automatic clearLogs();
    gotPc.delete();
    gotInsn.delete();
    reqAddr.delete();
  endtask

  task automatic drainAndRedirect(input logic [31:0] target);
    imem_ready = 1'b0;
    insn_ready = 1'b1;
    redirect_valid = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = target;
    tick();
    redirect_valid = 1'b0;
    clearLogs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    memAuto = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0000_0000;
    imem_ready = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 32'h0000_0000;
    insn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (insn_valid !== 1'b0) begin errors++; $display("FAIL reset_insn_valid got %b want 0", insn_valid); end
    end
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++;
    if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL reset_addr got %h want 00000000", imem_addr); end
    checks++;
    if (insn !== 32'h0000_0000) begin errors++; $display("FAIL reset_insn got %h want 00000000", insn); end
    checks++;
    if (insn_pc !== 32'h0000_0000) begin errors++; $display("FAIL reset_insn_pc got %h want 00000000", insn_pc); end
  endtask

  task automatic test_sequential();
    clearLogs();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL seq_first_req got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
    end
    tick();
    checks++;
    if (imem_req !== 1'b0 || insn_valid !== 1'b0) begin
      errors++; $display("FAIL seq_wait got req=%b insn_valid=%b want 0 0", imem_req, insn_valid);
    end
    tick();
    checks++;
    if (insn_valid !== 1'b1 || insn_pc !== 32'h0 || insn !== memData(32'h0)) begin
      errors++; $display("FAIL seq_latency got v=%b pc=%h insn=%h want 1 00000000 %h", insn_valid, insn_pc, insn, memData(32'h0));
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL seq_second_req got req=%b addr=%h want 1 00000004", imem_req, imem_addr);
    end
    repeat (10) tick();
    checks++;
    if (gotPc.size() < 4 || reqAddr.size() < 4) begin
      errors++; $display("FAIL seq_count got pcs=%0d reqs=%0d want >=4", gotPc.size(), reqAddr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (reqAddr[i] !== 32'(4 * i) || gotPc[i] !== 32'(4 * i) || gotInsn[i] !== memData(32'(4 * i))) begin
          errors++; $display("FAIL seq_order[%0d] got addr=%h pc=%h insn=%h want %h", i, reqAddr[i], gotPc[i], gotInsn[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    drainAndRedirect(32'h0000_0040);
    insn_ready = 1'b0;
    imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5 || i == 9) begin
        checks++;
        if (insn_valid !== 1'b1 || insn_pc !== 32'h40 || insn !== memData(32'h40)) begin
          errors++; $display("FAIL bp_hold[%0d] got v=%b pc=%h insn=%h want 1 00000040", i, insn_valid, insn_pc, insn);
        end
      end
    end
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low got %b want 0", imem_req); end
    checks++;
    if (reqAddr.size() != 2) begin
      errors++; $display("FAIL bp_fetch_count got %0d want 2", reqAddr.size());
    end
    imem_ready = 1'b0;
    insn_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (gotPc.size() != 2 || gotPc[0] !== 32'h40 || gotPc[1] !== 32'h44) begin
      errors++; $display("FAIL bp_release got n=%0d first=%h want 2 00000040,00000044", gotPc.size(), gotPc[0]);
    end
    checks++;
    if (insn_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", insn_valid); end
    clearLogs();
    imem_ready = 1'b1;
    repeat (8) tick();
    checks++;
    if (gotPc.size() < 2 || gotPc[0] !== 32'h48 || gotPc[1] !== 32'h4C) begin
      errors++; $display("FAIL bp_continue got n=%0d first=%h want 00000048,0000004c", gotPc.size(), gotPc[0]);
    end
  endtask

  task automatic test_redirect_wait();
    drainAndRedirect(32'h0000_0080);
    memAuto = 1'b0;
    imem_valid = 1'b0;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || insn_valid !== 1'b0) begin
      errors++; $display("FAIL rw_drop got req=%b v=%b want 0 0", imem_req, insn_valid);
    end
    imem_valid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || insn_valid !== 1'b0) begin
      errors++; $display("FAIL rw_target got req=%b addr=%h v=%b want 1 00000100 0", imem_req, imem_addr, insn_valid);
    end
    clearLogs();
    memAuto = 1'b1;
    imem_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (gotPc.size() < 1 || gotPc[0] !== 32'h100 || gotInsn[0] !== memData(32'h100)) begin
      errors++; $display("FAIL rw_first_insn got n=%0d pc=%h insn=%h want 00000100", gotPc.size(), gotPc[0], gotInsn[0]);
    end
  endtask

  task automatic test_redirect_coincident();
    drainAndRedirect(32'h0000_0180);
    imem_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    imem_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || insn_valid !== 1'b0) begin
      errors++; $display("FAIL rc_valid got req=%b addr=%h v=%b want 1 00000200 0", imem_req, imem_addr, insn_valid);
    end
    clearLogs();
    imem_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (gotPc.size() < 1 || gotPc[0] !== 32'h200) begin
      errors++; $display("FAIL rc_valid_resume got n=%0d pc=%h want 00000200", gotPc.size(), gotPc[0]);
    end
    drainAndRedirect(32'h0000_0280);
    imem_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    imem_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rc_accept_drop got req=%b want 0", imem_req); end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300 || insn_valid !== 1'b0) begin
      errors++; $display("FAIL rc_accept got req=%b addr=%h v=%b want 1 00000300 0", imem_req, imem_addr, insn_valid);
    end
    clearLogs();
    imem_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (gotPc.size() < 1 || gotPc[0] !== 32'h300 || gotInsn[0] !== memData(32'h300)) begin
      errors++; $display("FAIL rc_accept_resume got n=%0d pc=%h want 00000300", gotPc.size(), gotPc[0]);
    end
  endtask

  task automatic test_stall_and_reset();
    drainAndRedirect(32'h0000_0500);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h500) begin
        errors++; $display("FAIL stall_addr[%0d] got req=%b addr=%h want 1 00000500", i, imem_req, imem_addr);
      end
    end
    memAuto = 1'b0;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst_n = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_DEAD;
    tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || insn_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid got req=%b addr=%h v=%b want 0 00000000 0", imem_req, imem_addr, insn_valid);
    end
    rst_n = 1'b1;
    tick();
    imem_valid = 1'b0;
    checks++;
    if (insn_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_late_valid got v=%b req=%b addr=%h want 0 1 00000000", insn_valid, imem_req, imem_addr);
    end
    clearLogs();
    memAuto = 1'b1;
    imem_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (reqAddr.size() < 1 || gotPc.size() < 1 || reqAddr[0] !== 32'h0 || gotPc[0] !== 32'h0 || gotInsn[0] !== memData(32'h0)) begin
      errors++; $display("FAIL rst_restart got addr=%h pc=%h want 00000000", reqAddr[0], gotPc[0]);
    end
  endtask

  task automatic test_wrap();
    drainAndRedirect(32'hFFFF_FFFF);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h want fffffffc", imem_addr); end
    imem_ready = 1'b1;
    repeat (8) tick();
    checks++;
    if (reqAddr.size() < 2 || reqAddr[0] !== 32'hFFFF_FFFC || reqAddr[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got n=%0d second=%h want fffffffc,00000000", reqAddr.size(), reqAddr[1]);
    end
    checks++;
    if (gotPc.size() < 2 || gotPc[0] !== 32'hFFFF_FFFC || gotPc[1] !== 32'h0 || gotInsn[1] !== memData(32'h0)) begin
      errors++; $display("FAIL wrap_insn got n=%0d pcs=%h,%h want fffffffc,00000000", gotPc.size(), gotPc[0], gotPc[1]);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_stall_and_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
